// File: rtl/act_pkg.sv
// act_pkg: shared types, fp16 constants, PLAN sigmoid breakpoints and the
// fp16 <-> S4.FRAC_W fixed-point conversion helpers for the activation pipe.
package act_pkg;

    localparam int unsigned FRAC_W   = 12;
    localparam int unsigned INT_W    = 4;
    localparam int unsigned MAG_W    = INT_W + FRAC_W;
    localparam int unsigned POS_W    = $clog2(MAG_W);
    localparam int unsigned FP_W     = 16;
    localparam int unsigned MANT_W   = 10;
    localparam int unsigned KEPT_W   = MANT_W + 1;
    localparam int unsigned SUM_W    = MANT_W + 2;
    localparam int unsigned EXP_BIAS = 15;
    // Exponent at which the 11-bit significand already sits at FRAC_W alignment
    localparam int unsigned FIX_EXP0 = EXP_BIAS + MANT_W - FRAC_W;
    localparam int unsigned EXP_SAT  = EXP_BIAS + INT_W;

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'b00,
        MODE_RELU    = 2'b01,
        MODE_TANH    = 2'b10,
        MODE_PASS    = 2'b11
    } act_mode_e;

    localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP_W-1:0] FP16_HALF = 16'h3800;
    localparam logic [FP_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP_W-1:0] FP16_PINF = 16'h7C00;

    localparam logic [MAG_W-1:0] FIX_ONE   = MAG_W'(1 << FRAC_W);
    localparam logic [MAG_W-1:0] FIX_MAX   = '1;
    localparam logic [MAG_W-1:0] PLAN_BP1  = MAG_W'(1 << FRAC_W);
    localparam logic [MAG_W-1:0] PLAN_BP2  = MAG_W'(19 << (FRAC_W - 3));
    localparam logic [MAG_W-1:0] PLAN_BP3  = MAG_W'(5 << FRAC_W);
    localparam logic [MAG_W-1:0] PLAN_OFF1 = MAG_W'(1 << (FRAC_W - 1));
    localparam logic [MAG_W-1:0] PLAN_OFF2 = MAG_W'(5 << (FRAC_W - 3));
    localparam logic [MAG_W-1:0] PLAN_OFF3 = MAG_W'(27 << (FRAC_W - 5));

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             sat;
        logic [MAG_W-1:0] mag;
    } fix_t;

    // fp16 to sign/magnitude fixed point; low bits truncate, large values clip
    function automatic fix_t fp16_to_fix(input logic [FP_W-1:0] h);
        fix_t          f;
        logic [4:0]    e;
        logic [MANT_W:0] sig;
        e      = h[14:10];
        sig    = {1'b1, h[MANT_W-1:0]};
        f.sign = h[15];
        f.nan  = 1'b0;
        f.sat  = 1'b0;
        f.mag  = '0;
        if (h[14:0] == FP16_PINF[14:0]) begin
            f.sat = 1'b1;
            f.mag = FIX_MAX;
        end else if (e == 5'h1F) begin
            f.nan = 1'b1;
        end else if (e >= 5'(EXP_SAT)) begin
            f.sat = 1'b1;
            f.mag = FIX_MAX;
        end else if (e >= 5'(FIX_EXP0)) begin
            f.mag = MAG_W'(sig) << (e - 5'(FIX_EXP0));
        end else if (e != 5'd0) begin
            f.mag = MAG_W'(sig) >> (5'(FIX_EXP0) - e);
        end
        return f;
    endfunction

    // Three-segment PLAN sigmoid on |x|, mirrored for negative inputs
    function automatic logic [MAG_W-1:0] plan_sigmoid(input logic sign,
                                                      input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] y;
        if (mag < PLAN_BP1)      y = (mag >> 2) + PLAN_OFF1;
        else if (mag < PLAN_BP2) y = (mag >> 3) + PLAN_OFF2;
        else if (mag < PLAN_BP3) y = (mag >> 5) + PLAN_OFF3;
        else                     y = FIX_ONE;
        if (sign) y = FIX_ONE - y;
        return y;
    endfunction

    // Sign/magnitude fixed point to fp16 with round-to-nearest-even
    function automatic logic [FP_W-1:0] fix_to_fp16(input logic sign,
                                                    input logic [MAG_W-1:0] mag);
        logic [POS_W-1:0]  p;
        logic [POS_W-1:0]  sh;
        logic [4:0]        e;
        logic [MAG_W-1:0]  low_mask;
        logic [KEPT_W-1:0] kept;
        logic [SUM_W-1:0]  sum;
        logic              rnd;
        logic [MANT_W-1:0] mant;
        p = '0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (mag[i]) p = POS_W'(i);
        end
        e = 5'(p) + 5'(EXP_BIAS - FRAC_W);
        if (p <= POS_W'(MANT_W)) begin
            mant = MANT_W'(mag << (POS_W'(MANT_W) - p));
        end else begin
            sh       = p - POS_W'(MANT_W);
            kept     = KEPT_W'(mag >> sh);
            low_mask = (MAG_W'(1) << (sh - POS_W'(1))) - MAG_W'(1);
            rnd      = mag[sh - POS_W'(1)] & ((|(mag & low_mask)) | kept[0]);
            sum      = {1'b0, kept} + SUM_W'(rnd);
            mant     = MANT_W'(sum);
            if (sum[SUM_W-1]) begin
                e    = e + 5'd1;
                mant = '0;
            end
        end
        return (mag == '0) ? FP16_ZERO : {sign, e, mant};
    endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: one fp16 lane of the activation pipe (S1 convert, S2 function,
// S3 back to fp16). Define ACT_TANH_EN to build the tanh path for mode 10.
module act_lane
    import act_pkg::*;
(
    input  logic            clk,
    input  logic            reset_b,
    input  logic            en1,
    input  logic            en2,
    input  logic            en3,
    input  logic [FP_W-1:0] in_data,
    input  act_mode_e       s1_mode,
    output logic [FP_W-1:0] out_data,
    output logic            out_sat
);

    fix_t             s1_fix;
    logic [FP_W-1:0]  s1_raw;
    logic             s2_byp;
    logic [FP_W-1:0]  s2_byp_data;
    logic             s2_sign;
    logic [MAG_W-1:0] s2_mag;
    logic             s2_sat;

    logic             s2_byp_c;
    logic [FP_W-1:0]  s2_byp_data_c;
    logic             s2_sign_c;
    logic [MAG_W-1:0] s2_mag_c;
    logic             s2_sat_c;

`ifdef ACT_TANH_EN
    logic [MAG_W:0]   tanh_dbl;
    logic [MAG_W-1:0] tanh_x2;
    logic [MAG_W-1:0] tanh_sig;
    logic [MAG_W:0]   tanh_two;
    logic [MAG_W:0]   tanh_one;
`endif

    // S2 function select; ReLU and pass bypass the fixed-point path bit-exact
    always_comb begin
        s2_byp_c      = 1'b1;
        s2_byp_data_c = s1_raw;
        s2_sign_c     = 1'b0;
        s2_mag_c      = '0;
        s2_sat_c      = 1'b0;
`ifdef ACT_TANH_EN
        tanh_dbl = {s1_fix.mag, 1'b0};
        tanh_x2  = tanh_dbl[MAG_W] ? FIX_MAX : tanh_dbl[MAG_W-1:0];
        tanh_sig = plan_sigmoid(s1_fix.sign, tanh_x2);
        tanh_two = {tanh_sig, 1'b0};
        tanh_one = {1'b0, FIX_ONE};
`endif
        case (s1_mode)
            MODE_SIGMOID: begin
                if (s1_fix.nan) begin
                    s2_byp_data_c = FP16_QNAN;
                end else begin
                    s2_byp_c = 1'b0;
                    s2_mag_c = plan_sigmoid(s1_fix.sign, s1_fix.mag);
                    s2_sat_c = s1_fix.sat;
                end
            end
            MODE_RELU: begin
                if (s1_fix.nan)     s2_byp_data_c = FP16_QNAN;
                else if (s1_raw[15]) s2_byp_data_c = FP16_ZERO;
            end
`ifdef ACT_TANH_EN
            // tanh(x) = 2*sigmoid(2x) - 1, signed result in Q1.FRAC_W
            MODE_TANH: begin
                if (s1_fix.nan) begin
                    s2_byp_data_c = FP16_QNAN;
                end else begin
                    s2_byp_c = 1'b0;
                    s2_sat_c = s1_fix.sat;
                    if (tanh_two >= tanh_one) begin
                        s2_mag_c = MAG_W'(tanh_two - tanh_one);
                    end else begin
                        s2_sign_c = 1'b1;
                        s2_mag_c  = MAG_W'(tanh_one - tanh_two);
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            s1_fix      <= '0;
            s1_raw      <= '0;
            s2_byp      <= 1'b0;
            s2_byp_data <= '0;
            s2_sign     <= 1'b0;
            s2_mag      <= '0;
            s2_sat      <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
        end else begin
            if (en1) begin
                s1_fix <= fp16_to_fix(in_data);
                s1_raw <= in_data;
            end
            if (en2) begin
                s2_byp      <= s2_byp_c;
                s2_byp_data <= s2_byp_data_c;
                s2_sign     <= s2_sign_c;
                s2_mag      <= s2_mag_c;
                s2_sat      <= s2_sat_c;
            end
            if (en3) begin
                out_data <= s2_byp ? s2_byp_data : fix_to_fp16(s2_sign, s2_mag);
                out_sat  <= s2_sat;
            end
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// activation_pipe: LANES-wide, 3-stage valid/ready fp16 activation unit.
// Define ACT_TANH_EN to enable tanh on mode 10 (otherwise mode 10 passes through).
module activation_pipe
    import act_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [LANES*FP_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_mode,
    output logic [LANES*FP_W-1:0] out_data,
    output logic [LANES-1:0]      out_sat
);

    logic      v1;
    logic      v2;
    act_mode_e m1;
    act_mode_e m2;
    logic      ld1;
    logic      ld2;
    logic      ld3;

    // A stage loads when empty or when its content moves on; bubbles collapse
    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            m1        <= MODE_SIGMOID;
            m2        <= MODE_SIGMOID;
            out_mode  <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) m1 <= act_mode_e'(in_mode);
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) m2 <= m1;
            end
            if (ld3) begin
                out_valid <= v2;
                if (v2) out_mode <= m2;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        act_lane u_lane (
            .clk      (clk),
            .reset_b  (reset_b),
            .en1      (ld1 && in_valid),
            .en2      (ld2 && v1),
            .en3      (ld3 && v2),
            .in_data  (in_data[FP_W*k +: FP_W]),
            .s1_mode  (m1),
            .out_data (out_data[FP_W*k +: FP_W]),
            .out_sat  (out_sat[k])
        );
    end

endmodule
